// File: rtl/axi_pkg.sv
// Shared types for the queued AXI4-Lite master: response codes and FSM state encodings.
package axi_pkg;

   typedef enum logic [1:0] {
      RespOkay   = 2'b00,
      RespExokay = 2'b01,
      RespSlverr = 2'b10,
      RespDecerr = 2'b11
   } axi_resp_e;

   typedef enum logic [1:0] {
      WIdle = 2'd0,
      WSend = 2'd1,
      WResp = 2'd2
   } wr_state_e;

   typedef enum logic [1:0] {
      RIdle = 2'd0,
      RAddr = 2'd1,
      RData = 2'd2
   } rd_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage. A push is dropped when full, even if a pop
// happens in the same cycle; the head is visible combinationally whenever not empty.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);

   // Extra MSB on each pointer separates full from empty.
   logic [PtrW:0]    wptr_q, wptr_d;
   logic [PtrW:0]    rptr_q, rptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty_o = (wptr_q == rptr_q);
   assign full_o  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                    (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
   assign head_o  = mem_q[rptr_q[PtrW-1:0]];

   // Pointer and storage next-state
   always_comb begin
      do_push = push_i && !full_o;
      do_pop  = pop_i && !empty_o;
      wptr_d  = wptr_q + {{PtrW{1'b0}}, do_push};
      rptr_d  = rptr_q + {{PtrW{1'b0}}, do_pop};
      mem_d   = mem_q;
      if (do_push) begin
         mem_d[wptr_q[PtrW-1:0]] = data_i;
      end
   end

   // Pointer registers; reset empties the queue
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // Storage array, contents are don't-care until written
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/axi_lite_master_queued.sv
// AXI4-Lite master: queues core load/store requests and runs independent read and write
// FSMs, each with a single outstanding transaction.
module axi_lite_master_queued
   import axi_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned WQ_DEPTH   = 2,
   parameter int unsigned RQ_DEPTH   = 2
) (
   input  logic                      CLK,
   input  logic                      RESETN,
   input  logic                      WREQ,
   output logic                      WREQ_READY,
   input  logic [ADDR_WIDTH-1:0]     IN_WADDR,
   input  logic [DATA_WIDTH-1:0]     IN_WDATA,
   input  logic [DATA_WIDTH/8-1:0]   IN_WMASK,
   output logic                      W_DONE,
   output logic                      W_ERR,
   input  logic                      RREQ,
   output logic                      RREQ_READY,
   input  logic [ADDR_WIDTH-1:0]     IN_RADDR,
   output logic [DATA_WIDTH-1:0]     DATA_OUT,
   output logic                      DATA_OUT_VALID,
   output logic                      R_ERR,
   output logic [ADDR_WIDTH-1:0]     AW_ADDR,
   output logic                      AW_VALID,
   input  logic                      AW_READY,
   output logic [DATA_WIDTH-1:0]     W_DATA,
   output logic [DATA_WIDTH/8-1:0]   W_STRB,
   output logic                      W_VALID,
   input  logic                      W_READY,
   input  logic [1:0]                B_RESP,
   input  logic                      B_VALID,
   output logic                      B_READY,
   output logic [ADDR_WIDTH-1:0]     AR_ADDR,
   output logic                      AR_VALID,
   input  logic                      AR_READY,
   input  logic [DATA_WIDTH-1:0]     R_DATA,
   input  logic [1:0]                R_RESP,
   input  logic                      R_VALID,
   output logic                      R_READY
);

   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
   localparam int unsigned WQ_WIDTH   = ADDR_WIDTH + DATA_WIDTH + STRB_WIDTH;

   // Only bit 1 of a response distinguishes error from success.
   logic unused_resp_lsb;
   assign unused_resp_lsb = B_RESP[0] ^ R_RESP[0];

   // ---------------------------------------------------------------- request queues
   logic                  wq_pop, wq_full, wq_empty;
   logic [WQ_WIDTH-1:0]   wq_head;
   logic                  rq_pop, rq_full, rq_empty;
   logic [ADDR_WIDTH-1:0] rq_head;

   sync_fifo #(
      .WIDTH (WQ_WIDTH),
      .DEPTH (WQ_DEPTH)
   ) u_wq (
      .clk_i   (CLK),
      .rst_ni  (RESETN),
      .push_i  (WREQ),
      .data_i  ({IN_WADDR, IN_WDATA, IN_WMASK}),
      .pop_i   (wq_pop),
      .head_o  (wq_head),
      .full_o  (wq_full),
      .empty_o (wq_empty)
   );

   sync_fifo #(
      .WIDTH (ADDR_WIDTH),
      .DEPTH (RQ_DEPTH)
   ) u_rq (
      .clk_i   (CLK),
      .rst_ni  (RESETN),
      .push_i  (RREQ),
      .data_i  (IN_RADDR),
      .pop_i   (rq_pop),
      .head_o  (rq_head),
      .full_o  (rq_full),
      .empty_o (rq_empty)
   );

   assign WREQ_READY = !wq_full;
   assign RREQ_READY = !rq_full;

   // ---------------------------------------------------------------- write path
   wr_state_e             wr_state_q, wr_state_d;
   logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
   logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
   logic [STRB_WIDTH-1:0] w_strb_q, w_strb_d;
   // AW and W complete independently; each pending flag drops after its own handshake.
   logic                  aw_pend_q, aw_pend_d;
   logic                  w_pend_q, w_pend_d;

   // Write FSM state and payload registers
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         wr_state_q <= WIdle;
         aw_addr_q  <= '0;
         w_data_q   <= '0;
         w_strb_q   <= '0;
         aw_pend_q  <= 1'b0;
         w_pend_q   <= 1'b0;
      end else begin
         wr_state_q <= wr_state_d;
         aw_addr_q  <= aw_addr_d;
         w_data_q   <= w_data_d;
         w_strb_q   <= w_strb_d;
         aw_pend_q  <= aw_pend_d;
         w_pend_q   <= w_pend_d;
      end
   end

   // Write FSM next-state: pop queue, track AW/W handshakes, wait for B
   always_comb begin
      wr_state_d = wr_state_q;
      aw_addr_d  = aw_addr_q;
      w_data_d   = w_data_q;
      w_strb_d   = w_strb_q;
      aw_pend_d  = aw_pend_q;
      w_pend_d   = w_pend_q;
      wq_pop     = 1'b0;
      unique case (wr_state_q)
         WIdle: begin
            if (!wq_empty) begin
               wq_pop                             = 1'b1;
               {aw_addr_d, w_data_d, w_strb_d}    = wq_head;
               aw_pend_d                          = 1'b1;
               w_pend_d                           = 1'b1;
               wr_state_d                         = WSend;
            end
         end
         WSend: begin
            if (aw_pend_q && AW_READY) aw_pend_d = 1'b0;
            if (w_pend_q && W_READY)   w_pend_d  = 1'b0;
            if (!aw_pend_d && !w_pend_d) wr_state_d = WResp;
         end
         WResp: begin
            if (B_VALID) wr_state_d = WIdle;
         end
         default: wr_state_d = WIdle;
      endcase
   end

   // Write channel outputs
   always_comb begin
      AW_VALID = (wr_state_q == WSend) && aw_pend_q;
      W_VALID  = (wr_state_q == WSend) && w_pend_q;
      B_READY  = (wr_state_q == WResp);
      W_DONE   = B_READY && B_VALID;
      W_ERR    = W_DONE && B_RESP[1];
      AW_ADDR  = aw_addr_q;
      W_DATA   = w_data_q;
      W_STRB   = w_strb_q;
   end

   // ---------------------------------------------------------------- read path
   rd_state_e             rd_state_q, rd_state_d;
   logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic                  r_err_q, r_err_d;
   logic                  dvalid_q, dvalid_d;

   // Read FSM state, address and returned-data registers
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         rd_state_q <= RIdle;
         ar_addr_q  <= '0;
         data_out_q <= '0;
         r_err_q    <= 1'b0;
         dvalid_q   <= 1'b0;
      end else begin
         rd_state_q <= rd_state_d;
         ar_addr_q  <= ar_addr_d;
         data_out_q <= data_out_d;
         r_err_q    <= r_err_d;
         dvalid_q   <= dvalid_d;
      end
   end

   // Read FSM next-state: pop queue, issue AR, capture R
   always_comb begin
      rd_state_d = rd_state_q;
      ar_addr_d  = ar_addr_q;
      data_out_d = data_out_q;
      r_err_d    = r_err_q;
      dvalid_d   = 1'b0;
      rq_pop     = 1'b0;
      unique case (rd_state_q)
         RIdle: begin
            if (!rq_empty) begin
               rq_pop     = 1'b1;
               ar_addr_d  = rq_head;
               rd_state_d = RAddr;
            end
         end
         RAddr: begin
            if (AR_READY) rd_state_d = RData;
         end
         RData: begin
            if (R_VALID) begin
               data_out_d = R_DATA;
               r_err_d    = R_RESP[1];
               dvalid_d   = 1'b1;
               rd_state_d = RIdle;
            end
         end
         default: rd_state_d = RIdle;
      endcase
   end

   // Read channel outputs
   always_comb begin
      AR_VALID       = (rd_state_q == RAddr);
      R_READY        = (rd_state_q == RData);
      AR_ADDR        = ar_addr_q;
      DATA_OUT       = data_out_q;
      DATA_OUT_VALID = dvalid_q;
      R_ERR          = r_err_q;
   end

endmodule

// File: tb/tb_axi_lite_master_queued.sv
// Directed bench for axi_lite_master_queued: a configurable AXI slave model, a scoreboard
// of expected bus/response events filled at request time, and a negedge monitor.
module tb_axi_lite_master_queued;
   import axi_pkg::*;

   localparam int unsigned AW = 64;
   localparam int unsigned DW = 64;
   localparam int unsigned SW = DW / 8;

   logic          CLK = 1'b0;
   logic          RESETN;
   logic          WREQ, WREQ_READY, W_DONE, W_ERR;
   logic [AW-1:0] IN_WADDR;
   logic [DW-1:0] IN_WDATA;
   logic [SW-1:0] IN_WMASK;
   logic          RREQ, RREQ_READY, DATA_OUT_VALID, R_ERR;
   logic [AW-1:0] IN_RADDR;
   logic [DW-1:0] DATA_OUT;
   logic [AW-1:0] AW_ADDR, AR_ADDR;
   logic          AW_VALID, AW_READY, W_VALID, W_READY, B_VALID, B_READY;
   logic          AR_VALID, AR_READY, R_VALID, R_READY;
   logic [DW-1:0] W_DATA, R_DATA;
   logic [SW-1:0] W_STRB;
   logic [1:0]    B_RESP, R_RESP;

   axi_lite_master_queued #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .WQ_DEPTH   (2),
      .RQ_DEPTH   (2)
   ) dut (
      .CLK            (CLK),
      .RESETN         (RESETN),
      .WREQ           (WREQ),
      .WREQ_READY     (WREQ_READY),
      .IN_WADDR       (IN_WADDR),
      .IN_WDATA       (IN_WDATA),
      .IN_WMASK       (IN_WMASK),
      .W_DONE         (W_DONE),
      .W_ERR          (W_ERR),
      .RREQ           (RREQ),
      .RREQ_READY     (RREQ_READY),
      .IN_RADDR       (IN_RADDR),
      .DATA_OUT       (DATA_OUT),
      .DATA_OUT_VALID (DATA_OUT_VALID),
      .R_ERR          (R_ERR),
      .AW_ADDR        (AW_ADDR),
      .AW_VALID       (AW_VALID),
      .AW_READY       (AW_READY),
      .W_DATA         (W_DATA),
      .W_STRB         (W_STRB),
      .W_VALID        (W_VALID),
      .W_READY        (W_READY),
      .B_RESP         (B_RESP),
      .B_VALID        (B_VALID),
      .B_READY        (B_READY),
      .AR_ADDR        (AR_ADDR),
      .AR_VALID       (AR_VALID),
      .AR_READY       (AR_READY),
      .R_DATA         (R_DATA),
      .R_RESP         (R_RESP),
      .R_VALID        (R_VALID),
      .R_READY        (R_READY)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   // Scoreboard queues, filled when a request is accepted.
   logic [AW-1:0]   exp_aw[$];
   logic [DW+SW-1:0] exp_w[$];
   logic            exp_b[$];
   logic [AW-1:0]   exp_ar[$];
   logic [DW:0]     exp_r[$];

   // Slave settings: cycles of VALID before READY, response latency, response codes.
   int            aw_stall = 0, w_stall = 0, b_stall = 0, ar_stall = 0, r_stall = 0;
   logic [1:0]    b_resp_k = RespOkay;
   logic [1:0]    r_resp_k = RespOkay;
   logic [DW-1:0] r_xor = '0;

   int wdone_cycles = 0;
   int dvalid_cycles = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got an event, expected none", name);
   endtask

   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   // ------------------------------------------------------------ slave model
   int            aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
   bit            aw_got, w_got, ar_got, aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic [AW-1:0] ar_lat;

   initial begin
      AW_READY = 0; W_READY = 0; B_VALID = 0; B_RESP = 0;
      AR_READY = 0; R_VALID = 0; R_DATA = 0; R_RESP = 0;
      forever begin
         @(posedge CLK);
         #1;
         if (RESETN !== 1'b1) begin
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            aw_got = 0; w_got = 0; ar_got = 0;
            aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
            AW_READY = 0; W_READY = 0; B_VALID = 0; AR_READY = 0; R_VALID = 0;
         end else begin
            if (aw_hs) aw_got = 1;
            if (w_hs)  w_got = 1;
            if (b_hs) begin aw_got = 0; w_got = 0; end
            if (ar_hs) ar_got = 1;
            if (r_hs)  ar_got = 0;

            AW_READY = AW_VALID && (aw_cnt >= aw_stall);
            if (AW_VALID && !AW_READY) aw_cnt++;
            aw_hs = AW_VALID && AW_READY;
            if (aw_hs) aw_cnt = 0;

            W_READY = W_VALID && (w_cnt >= w_stall);
            if (W_VALID && !W_READY) w_cnt++;
            w_hs = W_VALID && W_READY;
            if (w_hs) w_cnt = 0;

            if (aw_got && w_got) begin
               B_VALID = (b_cnt >= b_stall);
               if (!B_VALID) b_cnt++;
            end else begin
               B_VALID = 0;
               b_cnt = 0;
            end
            B_RESP = b_resp_k;
            b_hs = B_VALID && B_READY;

            AR_READY = AR_VALID && (ar_cnt >= ar_stall);
            if (AR_VALID && !AR_READY) ar_cnt++;
            ar_hs = AR_VALID && AR_READY;
            if (ar_hs) begin ar_cnt = 0; ar_lat = AR_ADDR; end

            if (ar_got) begin
               R_VALID = (r_cnt >= r_stall);
               if (!R_VALID) r_cnt++;
            end else begin
               R_VALID = 0;
               r_cnt = 0;
            end
            R_DATA = ar_lat ^ r_xor;
            R_RESP = r_resp_k;
            r_hs = R_VALID && R_READY;
         end
      end
   end

   // ------------------------------------------------------------ monitor
   bit            aw_wait_prev, w_wait_prev, ar_wait_prev;
   logic [AW-1:0] aw_addr_prev, ar_addr_prev;
   logic [DW+SW-1:0] w_pay_prev;

   initial begin
      forever begin
         @(negedge CLK);
         if (RESETN !== 1'b1) begin
            aw_wait_prev = 0; w_wait_prev = 0; ar_wait_prev = 0;
         end else begin
            if (aw_wait_prev) begin
               chk("aw_valid_held", AW_VALID, 1'b1);
               chk("aw_addr_stable", AW_ADDR, aw_addr_prev);
            end
            if (w_wait_prev) begin
               chk("w_valid_held", W_VALID, 1'b1);
               chk("w_payload_stable", {W_DATA, W_STRB}, w_pay_prev);
            end
            if (ar_wait_prev) begin
               chk("ar_valid_held", AR_VALID, 1'b1);
               chk("ar_addr_stable", AR_ADDR, ar_addr_prev);
            end
            aw_wait_prev = AW_VALID && !AW_READY;
            w_wait_prev  = W_VALID && !W_READY;
            ar_wait_prev = AR_VALID && !AR_READY;
            aw_addr_prev = AW_ADDR;
            w_pay_prev   = {W_DATA, W_STRB};
            ar_addr_prev = AR_ADDR;

            if (AW_VALID && AW_READY) begin
               if (exp_aw.size() == 0) unexpected("aw_handshake");
               else chk("aw_addr", AW_ADDR, exp_aw.pop_front());
            end
            if (W_VALID && W_READY) begin
               if (exp_w.size() == 0) unexpected("w_handshake");
               else chk("w_data_strb", {W_DATA, W_STRB}, exp_w.pop_front());
            end
            if (W_DONE) begin
               wdone_cycles++;
               if (exp_b.size() == 0) unexpected("w_done");
               else chk("w_err", W_ERR, exp_b.pop_front());
            end
            if (AR_VALID && AR_READY) begin
               if (exp_ar.size() == 0) unexpected("ar_handshake");
               else chk("ar_addr", AR_ADDR, exp_ar.pop_front());
            end
            if (DATA_OUT_VALID) begin
               dvalid_cycles++;
               if (exp_r.size() == 0) unexpected("data_out_valid");
               else chk("data_out_err", {DATA_OUT, R_ERR}, exp_r.pop_front());
            end
         end
      end
   end

   // ------------------------------------------------------------ stimulus helpers
   task automatic push_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [SW-1:0] m, input logic err);
      int n = 0;
      while (!WREQ_READY && n < 200) begin tick(); n++; end
      if (!WREQ_READY) begin
         chk("wreq_ready_timeout", WREQ_READY, 1'b1);
      end else begin
         WREQ = 1; IN_WADDR = a; IN_WDATA = d; IN_WMASK = m;
         exp_aw.push_back(a);
         exp_w.push_back({d, m});
         exp_b.push_back(err);
         tick();
         WREQ = 0;
      end
   endtask

   task automatic push_read(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic err);
      int n = 0;
      while (!RREQ_READY && n < 200) begin tick(); n++; end
      if (!RREQ_READY) begin
         chk("rreq_ready_timeout", RREQ_READY, 1'b1);
      end else begin
         RREQ = 1; IN_RADDR = a;
         exp_ar.push_back(a);
         exp_r.push_back({d, err});
         tick();
         RREQ = 0;
      end
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((exp_aw.size() + exp_w.size() + exp_b.size() + exp_ar.size() + exp_r.size()) != 0
             && n < 300) begin
         tick();
         n++;
      end
      chk(name, exp_aw.size() + exp_w.size() + exp_b.size() + exp_ar.size() + exp_r.size(), 0);
      tick();
      tick();
   endtask

   task automatic check_idle_outputs(input string name);
      chk({name, "_aw_valid"}, AW_VALID, 1'b0);
      chk({name, "_w_valid"}, W_VALID, 1'b0);
      chk({name, "_b_ready"}, B_READY, 1'b0);
      chk({name, "_ar_valid"}, AR_VALID, 1'b0);
      chk({name, "_r_ready"}, R_READY, 1'b0);
      chk({name, "_w_done"}, {W_DONE, W_ERR}, 2'b00);
      chk({name, "_dvalid"}, {DATA_OUT_VALID, R_ERR}, 2'b00);
      chk({name, "_data_out"}, DATA_OUT, 64'h0);
      chk({name, "_aw_addr"}, AW_ADDR, 64'h0);
      chk({name, "_w_data_strb"}, {W_DATA, W_STRB}, 72'h0);
      chk({name, "_ar_addr"}, AR_ADDR, 64'h0);
      chk({name, "_queues_empty"}, {WREQ_READY, RREQ_READY}, 2'b11);
   endtask

   // ------------------------------------------------------------ watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected run to complete");
      $fatal(1, "watchdog expired");
   end

   // ------------------------------------------------------------ directed tests
   initial begin
      int n;
      RESETN = 0; WREQ = 0; RREQ = 0;
      IN_WADDR = '0; IN_WDATA = '0; IN_WMASK = '0; IN_RADDR = '0;
      repeat (3) tick();
      check_idle_outputs("reset");
      RESETN = 1;
      tick();

      // Single write, slave ready at once: bus handshake two cycles after acceptance.
      wdone_cycles = 0;
      push_write(64'h0000_0000_8000_0010, 64'h0000_0000_DEAD_BEEF, 8'h0F, 1'b0);
      chk("t1_no_bypass", {AW_VALID, W_VALID}, 2'b00);
      tick();
      chk("t1_aw_w_valid_n2", {AW_VALID, W_VALID}, 2'b11);
      chk("t1_aw_addr_n2", AW_ADDR, 64'h0000_0000_8000_0010);
      tick();
      chk("t1_wresp_state", {AW_VALID, W_VALID, B_READY}, 3'b001);
      chk("t1_w_done_pulse", {W_DONE, W_ERR}, 2'b10);
      drain("t1_drain");
      chk("t1_one_done_pulse", wdone_cycles, 1);

      // AW_READY held off: W finishes first, AW held 3 cycles, B_READY only after both.
      aw_stall = 2;
      push_write(64'h0000_0000_1000_0020, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0);
      tick();
      chk("t2_n2", {AW_VALID, W_VALID, B_READY}, 3'b110);
      tick();
      chk("t2_n3", {AW_VALID, W_VALID, B_READY}, 3'b100);
      tick();
      chk("t2_n4", {AW_VALID, W_VALID, B_READY}, 3'b100);
      tick();
      chk("t2_n5", {AW_VALID, W_VALID, B_READY}, 3'b001);
      drain("t2_drain");
      aw_stall = 0;

      // Write error response reported on W_ERR.
      b_resp_k = RespDecerr;
      push_write(64'h0000_0000_0000_0100, 64'hFFFF_0000_FFFF_0000, 8'h3C, 1'b1);
      drain("t2b_drain");
      b_resp_k = RespOkay;

      // Read with SLVERR: slave returns addr ^ r_xor = 0x1000 ^ 0x0234 = 0x1234.
      dvalid_cycles = 0;
      r_resp_k = RespSlverr;
      r_xor = 64'h0234;
      push_read(64'h0000_0000_0000_1000, 64'h0000_0000_0000_1234, 1'b1);
      chk("t3_no_bypass", AR_VALID, 1'b0);
      tick();
      chk("t3_ar_valid_n2", AR_VALID, 1'b1);
      tick();
      chk("t3_r_ready_n3", R_READY, 1'b1);
      tick();
      chk("t3_dvalid_n4", {DATA_OUT_VALID, DATA_OUT, R_ERR}, {1'b1, 64'h1234, 1'b1});
      tick();
      chk("t3_dvalid_drop_n5", DATA_OUT_VALID, 1'b0);
      drain("t3_drain");
      chk("t3_one_dvalid_pulse", dvalid_cycles, 1);
      r_resp_k = RespOkay;
      r_xor = '0;

      // Queue fill with AR stalled: one in flight plus two queued, the next is refused.
      ar_stall = 1000;
      push_read(64'h100, 64'h100, 1'b0);
      push_read(64'h200, 64'h200, 1'b0);
      push_read(64'h300, 64'h300, 1'b0);
      chk("t4_rreq_ready_full", RREQ_READY, 1'b0);
      RREQ = 1; IN_RADDR = 64'h400;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t4_refused_while_full", RREQ_READY, 1'b0);
      end
      RREQ = 0;
      ar_stall = 0;
      push_read(64'h400, 64'h400, 1'b0);
      drain("t4_drain");

      // Concurrent: write slave stalled on B, read completes meanwhile.
      b_stall = 20; r_stall = 3;
      push_write(64'h2000, 64'hCAFE, 8'h03, 1'b0);
      push_read(64'h3000, 64'h3000, 1'b0);
      n = 0;
      while (exp_r.size() != 0 && n < 200) begin tick(); n++; end
      chk("t5a_read_done", exp_r.size(), 0);
      chk("t5a_write_still_pending", exp_b.size(), 1);
      drain("t5a_drain");

      // Concurrent: read slave stalled on AR, write completes meanwhile.
      b_stall = 0; r_stall = 0; ar_stall = 20;
      push_read(64'h3100, 64'h3100, 1'b0);
      push_write(64'h2100, 64'hBEEF, 8'hC0, 1'b0);
      n = 0;
      while (exp_b.size() != 0 && n < 200) begin tick(); n++; end
      chk("t5b_write_done", exp_b.size(), 0);
      chk("t5b_read_still_pending", exp_r.size(), 1);
      drain("t5b_drain");
      ar_stall = 0;

      // Reset while waiting for B, with requests still queued.
      b_stall = 1000; ar_stall = 1000;
      push_write(64'h4000, 64'h1111, 8'h01, 1'b0);
      push_write(64'h5000, 64'h2222, 8'h02, 1'b0);
      push_read(64'h6000, 64'h6000, 1'b0);
      n = 0;
      while (!B_READY && n < 50) begin tick(); n++; end
      chk("t6_reached_wresp", B_READY, 1'b1);
      RESETN = 0;
      exp_aw.delete(); exp_w.delete(); exp_b.delete(); exp_ar.delete(); exp_r.delete();
      tick();
      tick();
      check_idle_outputs("mid_reset");
      b_stall = 0; ar_stall = 0;
      RESETN = 1;
      repeat (4) tick();
      chk("t6_queues_flushed", {AW_VALID, W_VALID, AR_VALID}, 3'b000);
      wdone_cycles = 0;
      push_write(64'h0000_0000_7000_0008, 64'h0000_0000_0000_55AA, 8'hF0, 1'b0);
      drain("t6_drain");
      chk("t6_write_after_reset", wdone_cycles, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
